// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word fetch at a time from the current PC,
// holds the returned word for the decoder, and follows redirects. A stale
// response still in flight when a redirect arrives is discarded through a
// kill flag. A misaligned redirect target is fatal: the unit parks in HALT
// until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misalign_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        FULL = 3'd3,
        HALT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        req_valid_q, req_valid_d;
    logic        misalign_q, misalign_d;

    logic        redir_ok;
    logic        redir_bad;

    assign redir_ok  = redirect && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect && (redirect_pc[1:0] != 2'b00);

    // Next-state and next-output computation; redirects take priority over
    // every memory or decoder event in the same cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        misalign_d = misalign_q;

        if (state_q != HALT && redir_bad) begin
            // Fatal: drop everything, any in-flight response is simply ignored.
            state_d    = HALT;
            misalign_d = 1'b1;
            kill_d     = 1'b0;
            instr_d    = 32'h0;
            instr_pc_d = 32'h0;
        end else if (state_q != HALT && redir_ok) begin
            pc_d    = redirect_pc;
            state_d = REQ;
            kill_d  = 1'b0;
            if (state_q == REQ && imem_req_ready) begin
                // The old request was accepted this cycle; its answer is stale.
                state_d = WAIT;
                kill_d  = 1'b1;
            end else if (state_q == WAIT && !imem_rsp_valid) begin
                // Still owed a response for the old PC; wait it out and drop it.
                state_d = WAIT;
                kill_d  = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_req_ready) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = REQ;
                        end else begin
                            instr_d    = imem_rsp_data;
                            instr_pc_d = pc_q;
                            pc_d       = pc_q + 32'd4;
                            state_d    = FULL;
                        end
                    end
                end
                FULL: begin
                    if (instr_ready) begin
                        state_d = REQ;
                    end
                end
                HALT: state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake outputs are registered decodes of the next state.
    assign req_valid_d   = (state_d == REQ);
    assign instr_valid_d = (state_d == FULL);

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            kill_q        <= 1'b0;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            req_valid_q   <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_q        <= kill_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            req_valid_q   <= req_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios for reset, back-pressure, redirect,
// wrap-around and misalignment, then a randomized run against a
// transaction-level model of the expected instruction stream.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misalign_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .misalign_err   (misalign_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Contents of the modelled instruction memory.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic clear_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
    endtask

    task automatic nclk();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_valid"}, imem_req_valid, 1'b0);
        check_eq({tag, "_addr"}, imem_addr, 32'h0);
        check_eq({tag, "_instr_valid"}, instr_valid, 1'b0);
        check_eq({tag, "_instr"}, instr, 32'h0);
        check_eq({tag, "_instr_pc"}, instr_pc, 32'h0);
        check_eq({tag, "_misalign"}, misalign_err, 1'b0);
    endtask

    // Randomized-run model state.
    logic        pending;
    int          cnt;
    logic [31:0] paddr;
    logic [31:0] exp_pc;
    logic        hold_prev;
    logic [31:0] hold_instr, hold_pc;
    int          deliveries;

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) nclk();
        check_reset_outputs("reset");

        // First fetch after reset.
        rst_n = 1'b1;
        check_eq("idle_no_req", imem_req_valid, 1'b0);
        nclk();
        check_eq("first_req", imem_req_valid, 1'b1);
        check_eq("first_addr", imem_addr, 32'h0);
        imem_req_ready = 1'b1;
        nclk();
        imem_req_ready = 1'b0;
        check_eq("wait_no_req", imem_req_valid, 1'b0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        nclk();
        imem_rsp_valid = 1'b0;
        check_eq("first_valid", instr_valid, 1'b1);
        check_eq("first_instr", instr, 32'h0000_0013);
        check_eq("first_pc", instr_pc, 32'h0);

        // Decoder back-pressure.
        for (int i = 0; i < 5; i++) begin
            nclk();
            check_eq("hold_valid", instr_valid, 1'b1);
            check_eq("hold_instr", instr, 32'h0000_0013);
            check_eq("hold_pc", instr_pc, 32'h0);
            check_eq("hold_no_req", imem_req_valid, 1'b0);
        end
        instr_ready = 1'b1;
        nclk();
        instr_ready = 1'b0;
        check_eq("consume_valid", instr_valid, 1'b0);
        check_eq("next_req", imem_req_valid, 1'b1);
        check_eq("next_addr", imem_addr, 32'h4);

        // Redirect while a response is owed; stale word must be dropped.
        imem_req_ready = 1'b1;
        nclk();
        imem_req_ready = 1'b0;
        redirect       = 1'b1;
        redirect_pc    = 32'h0000_0100;
        nclk();
        redirect = 1'b0;
        check_eq("kill_wait_req", imem_req_valid, 1'b0);
        check_eq("kill_addr", imem_addr, 32'h100);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        nclk();
        imem_rsp_valid = 1'b0;
        check_eq("stale_dropped", instr_valid, 1'b0);
        check_eq("refetch_req", imem_req_valid, 1'b1);
        check_eq("refetch_addr", imem_addr, 32'h100);
        imem_req_ready = 1'b1;
        nclk();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        nclk();
        imem_rsp_valid = 1'b0;
        check_eq("redir_valid", instr_valid, 1'b1);
        check_eq("redir_instr", instr, 32'h1234_5678);
        check_eq("redir_pc", instr_pc, 32'h100);

        // Redirect in FULL with decoder ready; then PC wrap.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        instr_ready = 1'b1;
        nclk();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        check_eq("full_redir_drop", instr_valid, 1'b0);
        check_eq("full_redir_req", imem_req_valid, 1'b1);
        check_eq("full_redir_addr", imem_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        nclk();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_0001;
        nclk();
        imem_rsp_valid = 1'b0;
        check_eq("wrap_instr", instr, 32'hCAFE_0001);
        check_eq("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        check_eq("wrap_addr", imem_addr, 32'h0);
        instr_ready = 1'b1;
        nclk();
        instr_ready = 1'b0;
        check_eq("wrap_req", imem_req_valid, 1'b1);
        check_eq("wrap_req_addr", imem_addr, 32'h0);

        // Asynchronous reset while waiting, then a late response.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        nclk();
        redirect = 1'b0;
        check_eq("pre_rst_addr", imem_addr, 32'h40);
        imem_req_ready = 1'b1;
        nclk();
        imem_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        nclk();
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        nclk();
        check_eq("late_rsp_valid", instr_valid, 1'b0);
        check_eq("late_rsp_req", imem_req_valid, 1'b1);
        nclk();
        imem_rsp_valid = 1'b0;
        check_eq("late_rsp_ignored", instr_valid, 1'b0);
        check_eq("late_addr", imem_addr, 32'h0);
        imem_req_ready = 1'b1;
        nclk();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0055;
        nclk();
        imem_rsp_valid = 1'b0;
        check_eq("post_rst_instr", instr, 32'h0000_0055);
        check_eq("post_rst_pc", instr_pc, 32'h0);

        // Misaligned redirect is fatal until reset.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        nclk();
        redirect = 1'b0;
        check_eq("mis_flag", misalign_err, 1'b1);
        check_eq("mis_valid", instr_valid, 1'b0);
        check_eq("mis_req", imem_req_valid, 1'b0);
        check_eq("mis_instr", instr, 32'h0);
        check_eq("mis_instr_pc", instr_pc, 32'h0);
        for (int i = 0; i < 5; i++) begin
            imem_req_ready = 1'b1;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
            instr_ready    = 1'b1;
            redirect       = (i % 2) == 0;
            redirect_pc    = 32'h0000_0200;
            nclk();
            check_eq("halt_flag", misalign_err, 1'b1);
            check_eq("halt_req", imem_req_valid, 1'b0);
            check_eq("halt_valid", instr_valid, 1'b0);
            check_eq("halt_addr", imem_addr, 32'h4);
        end
        clear_inputs();
        rst_n = 1'b0;
        #1 check_eq("mis_cleared", misalign_err, 1'b0);
        nclk();
        rst_n = 1'b1;

        // Randomized run against the stream model.
        pending    = 1'b0;
        cnt        = 0;
        paddr      = 32'h0;
        exp_pc     = 32'h0;
        hold_prev  = 1'b0;
        hold_instr = 32'h0;
        hold_pc    = 32'h0;
        deliveries = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic rsp_v, rdy, rr, rd, grant;
            logic [31:0] rpc;
            nclk();
            if (hold_prev) begin
                check_eq("rnd_stable_valid", instr_valid, 1'b1);
                check_eq("rnd_stable_instr", instr, hold_instr);
                check_eq("rnd_stable_pc", instr_pc, hold_pc);
            end
            check_eq("rnd_exclusive", imem_req_valid & instr_valid, 1'b0);
            rsp_v = pending && (cnt == 0);
            rr    = ($urandom % 4) != 0;
            rdy   = ($urandom % 3) != 0;
            rd    = ($urandom % 12) == 0;
            rpc   = (($urandom % 8) == 0) ? 32'hFFFF_FFFC : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            imem_rsp_valid = rsp_v;
            imem_rsp_data  = rsp_v ? mem_word(paddr) : $urandom;
            imem_req_ready = rr;
            instr_ready    = rdy;
            redirect       = rd;
            redirect_pc    = rpc;

            grant = imem_req_valid && rr;
            if (grant) begin
                check_eq("rnd_one_outstanding", pending, 1'b0);
                if (!rd) check_eq("rnd_req_addr", imem_addr, exp_pc);
            end
            if (instr_valid && rdy && !rd) begin
                check_eq("rnd_instr_pc", instr_pc, exp_pc);
                check_eq("rnd_instr", instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
            if (rd) exp_pc = rpc;
            hold_prev  = instr_valid && !rdy && !rd;
            hold_instr = instr;
            hold_pc    = instr_pc;

            if (rsp_v) pending = 1'b0;
            else if (pending) cnt--;
            if (grant) begin
                pending = 1'b1;
                cnt     = $urandom % 3;
                paddr   = imem_addr;
            end
        end
        check_eq("rnd_progress", deliveries > 100, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
